uart_alu_intf: RTL and testbench
================================

# uart_alu_intf

Host-side endpoint of the UART FIFO interface: pops received bytes from the RX FIFO, assembles a three-byte command frame (operand A, operand B, opcode), presents it to an external combinational ALU, and pushes the one-byte result into the TX FIFO. It sits between the `uart` top (its `rd_uart`/`r_data`/`rx_empty`/`wr_uart`/`w_data`/`tx_full` ports) and the ALU. It is the consumer/producer on the opposite side of the FIFOs the UART fills and drains.

## Interface
- `DBIT`, 8: data/operand/result width; matches the UART word.
- `NB_OP`, 6: opcode width; taken from the low `NB_OP` bits of the third byte.
- `TIMEOUT`, 1_000_000: idle-cycle limit for an incomplete frame. Used only with `UART_INTF_TIMEOUT_EN`.
- `TO_BITS`, 20: timeout counter width. Must satisfy `2^TO_BITS > TIMEOUT`.

- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_empty`  in  1  RX FIFO empty flag.
- `r_data`  in  DBIT  RX FIFO head word. Valid whenever `rx_empty`=0.
- `rd_uart`  out  1  RX FIFO pop strobe.
- `tx_full`  in  1  TX FIFO full flag.
- `wr_uart`  out  1  TX FIFO push strobe.
- `w_data`  out  DBIT  TX FIFO write word.
- `alu_a`, `alu_b`  out  DBIT  registered operands to the ALU.
- `alu_op`  out  NB_OP  registered opcode to the ALU.
- `alu_result`  in  DBIT  combinational ALU output.
- `done_tick`  out  1  one-cycle pulse in the cycle `wr_uart` is asserted.
- `timeout_tick`  out  1  one-cycle pulse when a partial frame is discarded. Tied to 0 without the macro.

## Operation
- FSM states: `RD_A`, `RD_B`, `RD_OP`, `EXEC`, `WR_RES`. Reset state is `RD_A`.
- Reset values: all outputs 0, `alu_a`/`alu_b`/`alu_op` 0, timeout counter 0.
- `RD_A`/`RD_B`/`RD_OP`, when `rx_empty`=0:
  - capture `r_data` into `alu_a`/`alu_b`/`alu_op` respectively (opcode = `r_data[NB_OP-1:0]`);
  - assert `rd_uart` for exactly that cycle;
  - advance to the next state.
- `RD_A`/`RD_B`/`RD_OP`, when `rx_empty`=1: hold state, `rd_uart`=0.
- `EXEC`: register `alu_result` into the result register; advance to `WR_RES` unconditionally.
- `WR_RES`, when `tx_full`=0: assert `wr_uart` and `done_tick` for one cycle with `w_data` = result register; go to `RD_A`.
- `WR_RES`, when `tx_full`=1: hold state with `wr_uart`=0. The result is never dropped.
- `rd_uart` and `wr_uart` are never asserted in the same cycle. `rd_uart` is never asserted while `rx_empty`=1. `wr_uart` is never asserted while `tx_full`=1.
- `w_data` holds its last value between writes.
- Reset mid-frame: all captured bytes are discarded and the FSM returns to `RD_A`. Bytes still in the FIFO are handled by the FIFO's own reset.

## Timing
- All strobes are registered outputs (Moore on the state, plus the registered flag sample). No combinational path from `rx_empty`/`tx_full` to the strobes.
- Back-to-back bytes are accepted one per cycle.
- Minimum latency, counting the cycle the first `rd_uart` is asserted as cycle 0:
  - cycles 0, 1, 2: `rd_uart` asserted for A, B, OP;
  - cycle 3: `EXEC`;
  - cycle 4: `wr_uart` asserted.
- The ALU path from `alu_a`/`alu_b`/`alu_op` to `alu_result` has one full cycle (the `EXEC` cycle) to settle.
- Timeout counter (macro on):
  - counts cycles spent in `RD_B` or `RD_OP` with `rx_empty`=1;
  - clears on every pop and in every other state;
  - on reaching `TIMEOUT`, next state is `RD_A` and `timeout_tick` pulses for one cycle;
  - a pop in the same cycle the limit is reached wins: no timeout occurs.

## Configuration
- `UART_INTF_TIMEOUT_EN` defined: the timeout counter and `timeout_tick` generation are compiled in. A stalled partial frame is dropped after `TIMEOUT` empty cycles.
- Not defined: no counter is instantiated and `timeout_tick`=0. A partial frame waits indefinitely for its remaining bytes.

## Structure
- Package `uart_intf_pkg`:
  - state enum `intf_state_t` (`RD_A`..`WR_RES`);
  - default width constants `DBIT_DEF`=8, `NB_OP_DEF`=6;
  - opcode constants used by the bench (`OP_ADD`=6'h20, `OP_SUB`=6'h22, `OP_AND`=6'h24).
- Sub-module `intf_timeout_cnt`: the counter with `clr`/`en`/`expired` ports. It is instantiated only under the macro.

## Test plan
- RX FIFO preloaded 0x05, 0x03, 0x20; bench ALU adds -> `rd_uart` high on 3 consecutive cycles, `wr_uart` two cycles later, `w_data`=0x08, `done_tick` pulses once.
- Bytes 0x10, 0x04, 0x22 arriving 50 cycles apart -> `rd_uart` pulses only when `rx_empty`=0, `w_data`=0x0C.
- `tx_full` held high for 20 cycles while in `WR_RES` -> `wr_uart` stays 0, then asserts on the first cycle `tx_full`=0 with `w_data` unchanged.
- `reset` driven low after byte A is popped, then released, then 0xFF, 0x0F, 0x24 supplied -> `w_data`=0x0F. No stale A is used.
- Macro on, `TIMEOUT`=100: byte 0x01 only -> `timeout_tick` pulses 100 cycles later, FSM returns to `RD_A`; next frame 0x02, 0x02, 0x20 -> `w_data`=0x04.
- Six frames streamed back-to-back -> six `wr_uart` pulses in frame order, minimum 5 cycles per frame.

Source files
------------

// File: rtl/uart_intf_pkg.sv
// Shared types and constants for the UART <-> ALU host interface.
package uart_intf_pkg;

  typedef enum logic [2:0] {
    RD_A,
    RD_B,
    RD_OP,
    EXEC,
    WR_RES
  } intf_state_t;

  localparam int unsigned DBIT_DEF  = 8;
  localparam int unsigned NB_OP_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;

endpackage

// File: rtl/uart_alu_intf_timeout_cnt.sv
// Idle-cycle counter that flags a stalled partial frame.
// Compiled only when UART_INTF_TIMEOUT_EN is defined.
`ifdef UART_INTF_TIMEOUT_EN
module intf_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned TO_BITS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_BITS-1:0] LAST = TO_BITS'(TIMEOUT - 1);

  logic [TO_BITS-1:0] cnt;

  // Count enabled cycles, restart on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_BITS'(1);
    end
  end

  // The enabled cycle that would bring the count to TIMEOUT is the expiry cycle.
  assign expired = en && !clr && (cnt == LAST);

endmodule
`endif

// File: rtl/uart_alu_intf.sv
// Host-side UART FIFO endpoint: pops A, B, opcode from the RX FIFO, runs them
// through an external combinational ALU and pushes the result to the TX FIFO.
// Optional feature macro: UART_INTF_TIMEOUT_EN (drop stalled partial frames).
module uart_alu_intf
  import uart_intf_pkg::*;
#(
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned NB_OP   = NB_OP_DEF,
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned TO_BITS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  alu_a,
  output logic [DBIT-1:0]  alu_b,
  output logic [NB_OP-1:0] alu_op,
  input  logic [DBIT-1:0]  alu_result,
  output logic             done_tick,
  output logic             timeout_tick
);

  intf_state_t     state;
  logic [DBIT-1:0] result;
  logic            to_expired;

  // Elaboration guard: the counter must be wide enough to reach TIMEOUT.
  if ((64'(TIMEOUT) >> TO_BITS) != 64'd0) begin : g_to_bits_check
    $error("TO_BITS too narrow for TIMEOUT");
  end

`ifdef UART_INTF_TIMEOUT_EN
  logic waiting;

  // Idle only while a frame is partially received and the RX FIFO is empty.
  assign waiting = ((state == RD_B) || (state == RD_OP)) && rx_empty;

  intf_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (!waiting),
    .en      (waiting),
    .expired (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  // Frame FSM. Strobes are registered on the same edge that captures the byte
  // or commits the write, so each strobe is high for the cycle after the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RD_A;
      rd_uart      <= 1'b0;
      wr_uart      <= 1'b0;
      done_tick    <= 1'b0;
      timeout_tick <= 1'b0;
      w_data       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result       <= '0;
    end else begin
      rd_uart      <= 1'b0;
      wr_uart      <= 1'b0;
      done_tick    <= 1'b0;
      timeout_tick <= 1'b0;
      unique case (state)
        RD_A: begin
          if (!rx_empty) begin
            alu_a   <= r_data;
            rd_uart <= 1'b1;
            state   <= RD_B;
          end
        end
        RD_B: begin
          if (!rx_empty) begin
            alu_b   <= r_data;
            rd_uart <= 1'b1;
            state   <= RD_OP;
          end else if (to_expired) begin
            timeout_tick <= 1'b1;
            state        <= RD_A;
          end
        end
        RD_OP: begin
          if (!rx_empty) begin
            alu_op  <= r_data[NB_OP-1:0];
            rd_uart <= 1'b1;
            state   <= EXEC;
          end else if (to_expired) begin
            timeout_tick <= 1'b1;
            state        <= RD_A;
          end
        end
        EXEC: begin
          result <= alu_result;
          state  <= WR_RES;
        end
        WR_RES: begin
          if (!tx_full) begin
            wr_uart   <= 1'b1;
            done_tick <= 1'b1;
            w_data    <= result;
            state     <= RD_A;
          end
        end
        default: state <= RD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Self-checking bench for uart_alu_intf: FIFO models, bench-side ALU,
// directed table, hand-written corner sequences and randomized frames.
module tb_uart_alu_intf;
  import uart_intf_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic [7:0] w_data, alu_a, alu_b, alu_result;
  logic [5:0] alu_op;
  logic       rd_uart, wr_uart, done_tick, timeout_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rd = 0, n_wr = 0, n_to = 0, n_done = 0;
  int to_cyc = 0;
  int rd_cyc[$];
  int wr_cyc[$];
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] last_w = 8'h00;
  logic tx_full_s = 1'b0;
  bit   rand_tx = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[6];

  always #5 clk = ~clk;

  uart_alu_intf #(
    .DBIT    (8),
    .NB_OP   (6),
    .TIMEOUT (100),
    .TO_BITS (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .rd_uart      (rd_uart),
    .tx_full      (tx_full),
    .wr_uart      (wr_uart),
    .w_data       (w_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .done_tick    (done_tick),
    .timeout_tick (timeout_tick)
  );

  // Reference arithmetic for the three bench opcodes; anything else yields 0.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return 8'h00;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb alu_result = ref_alu(alu_a, alu_b, alu_op);

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void refresh();
    rx_empty = (rxq.size() == 0);
    if (rxq.size() != 0) r_data = rxq[0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    rxq.push_back(b);
    refresh();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op, input logic [7:0] exp, input int gap);
    expq.push_back(exp);
    push_byte(a);
    repeat (gap) tick();
    push_byte(b);
    repeat (gap) tick();
    push_byte(op);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int i = 0;
    while (n_wr < target && i < budget) begin
      tick();
      i++;
    end
    check(name, n_wr, target);
  endtask

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tx_full_s <= tx_full;
  end

  // FIFO/TX monitor: pops the RX model on each read strobe, scores each write.
  always @(negedge clk) begin
    if (reset) begin
      if (rd_uart) begin
        check("rd_wr_exclusive", int'(wr_uart), 0);
        check("rd_nonempty", int'(rxq.size() != 0), 1);
        if (rxq.size() != 0) void'(rxq.pop_front());
        n_rd++;
        rd_cyc.push_back(cyc);
      end
      if (done_tick) n_done++;
      if (done_tick && !wr_uart) check("done_without_wr", int'(done_tick), 0);
      if (wr_uart) begin
        check("wr_not_full", int'(tx_full_s), 0);
        check("done_with_wr", int'(done_tick), 1);
        n_wr++;
        wr_cyc.push_back(cyc);
        check("write_expected", int'(expq.size() != 0), 1);
        if (expq.size() != 0) check("w_data", int'(w_data), int'(expq.pop_front()));
        last_w = w_data;
      end
      if (timeout_tick) begin
        n_to++;
        to_cyc = cyc;
      end
    end
    refresh();
  end

  initial forever begin
    tick();
    if (rand_tx) tx_full = ($urandom_range(0, 3) == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int w0, d0, to0;
    logic [7:0] prev;

    tv[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, exp: 8'h08};
    tv[1] = '{a: 8'h10, b: 8'h04, op: 8'h22, exp: 8'h0C};
    tv[2] = '{a: 8'hFF, b: 8'h0F, op: 8'h24, exp: 8'h0F};
    tv[3] = '{a: 8'h80, b: 8'h80, op: 8'h20, exp: 8'h00};
    tv[4] = '{a: 8'h00, b: 8'h01, op: 8'h22, exp: 8'hFF};
    tv[5] = '{a: 8'h3C, b: 8'h0F, op: 8'hE4, exp: 8'h0C};

    // Reset values
    reset = 1'b0;
    repeat (3) tick();
    check("rst_rd_uart", int'(rd_uart), 0);
    check("rst_wr_uart", int'(wr_uart), 0);
    check("rst_w_data", int'(w_data), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_done", int'(done_tick), 0);
    check("rst_timeout", int'(timeout_tick), 0);
    reset = 1'b1;
    tick();

    // Preloaded frame: minimum latency
    rd_cyc.delete(); wr_cyc.delete();
    w0 = n_wr; d0 = n_done;
    send_frame(8'h05, 8'h03, 8'h20, 8'h08, 0);
    wait_writes(w0 + 1, 40, "t1_write");
    repeat (3) tick();
    check("t1_rd_count", rd_cyc.size(), 3);
    check("t1_done_count", n_done - d0, 1);
    if (rd_cyc.size() == 3 && wr_cyc.size() == 1) begin
      check("t1_rd_b_next", rd_cyc[1] - rd_cyc[0], 1);
      check("t1_rd_op_next", rd_cyc[2] - rd_cyc[1], 1);
      check("t1_wr_latency", wr_cyc[0] - rd_cyc[2], 2);
    end

    // Bytes 50 cycles apart
    rd_cyc.delete();
    w0 = n_wr;
    send_frame(8'h10, 8'h04, 8'h22, 8'h0C, 50);
    wait_writes(w0 + 1, 40, "t2_write");
    check("t2_rd_count", rd_cyc.size(), 3);
    if (rd_cyc.size() == 3) begin
      check("t2_gap_ab", rd_cyc[1] - rd_cyc[0], 50);
      check("t2_gap_bop", rd_cyc[2] - rd_cyc[1], 50);
    end

    // TX FIFO full while holding a result
    w0 = n_wr;
    prev = last_w;
    tx_full = 1'b1;
    send_frame(8'h21, 8'h11, 8'h22, 8'h10, 0);
    repeat (25) tick();
    check("t3_no_write_full", n_wr, w0);
    check("t3_w_data_held", int'(w_data), int'(prev));
    tx_full = 1'b0;
    @(posedge clk);
    #1;
    check("t3_wr_after_release", int'(wr_uart), 1);
    check("t3_w_data_release", int'(w_data), 8'h10);
    tick();

    // Reset after byte A popped
    push_byte(8'h77);
    repeat (3) tick();
    check("t4_a_captured", int'(alu_a), 8'h77);
    reset = 1'b0;
    tick();
    check("t4_a_cleared", int'(alu_a), 0);
    reset = 1'b1;
    tick();
    w0 = n_wr;
    send_frame(8'hFF, 8'h0F, 8'h24, 8'h0F, 0);
    wait_writes(w0 + 1, 40, "t4_write");

    // Stalled partial frame
    w0 = n_wr; to0 = n_to;
    rd_cyc.delete();
    push_byte(8'h01);
`ifdef UART_INTF_TIMEOUT_EN
    for (int i = 0; i < 200 && n_to == to0; i++) tick();
    check("t5_timeout_count", n_to - to0, 1);
    if (rd_cyc.size() == 1) check("t5_timeout_latency", to_cyc - rd_cyc[0], 100);
    tick();
    check("t5_timeout_pulse", int'(timeout_tick), 0);
    check("t5_no_write", n_wr, w0);
    send_frame(8'h02, 8'h02, 8'h20, 8'h04, 0);
    wait_writes(w0 + 1, 40, "t5_write");
`else
    repeat (150) tick();
    check("t5_no_timeout", n_to, to0);
    check("t5_no_write", n_wr, w0);
    expq.push_back(8'h03);
    push_byte(8'h02);
    push_byte(8'h20);
    wait_writes(w0 + 1, 40, "t5_write");
`endif

    // Six table frames back-to-back
    tick();
    wr_cyc.delete();
    w0 = n_wr;
    foreach (tv[i]) send_frame(tv[i].a, tv[i].b, tv[i].op, tv[i].exp, 0);
    wait_writes(w0 + 6, 100, "t6_writes");
    if (wr_cyc.size() == 6) begin
      for (int i = 1; i < 6; i++) check("t6_frame_spacing", wr_cyc[i] - wr_cyc[i-1], 5);
    end

    // Randomized frames with random gaps and TX back-pressure
    rand_tx = 1'b1;
    w0 = n_wr;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b, opb;
      logic [5:0] op;
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 3))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        default: op = 6'($urandom);
      endcase
      opb = {2'($urandom), op};
      send_frame(a, b, opb, ref_alu(a, b, op), $urandom_range(0, 3));
    end
    wait_writes(w0 + 40, 2000, "t7_writes");
    rand_tx = 1'b0;
    tx_full = 1'b0;
    check("t7_queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
